// File: rtl/instruction_type_pkg.sv
// Shared instruction-type definitions: encoding formats, opcodes, control states and
// instruction classes, plus small per-class datapath helpers.
package instruction_type;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } instr_format_e;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_e;

   typedef enum logic [2:0] {
      CLS_R      = 3'd0,
      CLS_I_ALU  = 3'd1,
      CLS_LOAD   = 3'd2,
      CLS_STORE  = 3'd3,
      CLS_BRANCH = 3'd4,
      CLS_AUIPC  = 3'd5,
      CLS_LUI    = 3'd6
   } instr_class_e;

   // ALU operand-A select encodings.
   localparam logic [1:0] ALU_A_PC   = 2'd0;
   localparam logic [1:0] ALU_A_ZERO = 2'd1;
   localparam logic [1:0] ALU_A_RS1  = 2'd2;

   function automatic logic alu_src_of(input instr_class_e cls);
      return !(cls == CLS_R || cls == CLS_BRANCH);
   endfunction

   function automatic logic [1:0] alu_a_sel_of(input instr_class_e cls);
      case (cls)
         CLS_AUIPC: return ALU_A_PC;
         CLS_LUI:   return ALU_A_ZERO;
         default:   return ALU_A_RS1;
      endcase
   endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier; unknown opcodes report legal_o = 0.
module instr_class_decode
   import instruction_type::*;
(
   input  logic [6:0]   opcode_i,
   output instr_class_e class_o,
   output logic         legal_o
);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      class_o = CLS_R;
      legal_o = 1'b1;
      case (opcode_i)
         OPC_R:      class_o = CLS_R;
         OPC_I_ALU:  class_o = CLS_I_ALU;
         OPC_LOAD:   class_o = CLS_LOAD;
         OPC_STORE:  class_o = CLS_STORE;
         OPC_BRANCH: class_o = CLS_BRANCH;
         OPC_AUIPC:  class_o = CLS_AUIPC;
         OPC_LUI:    class_o = CLS_LUI;
         default:    legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: fetch/decode/execute/memory/writeback sequencing
// with a sticky trap on illegal opcodes.
module multicycle_control
   import instruction_type::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode_i,
   input  logic       br_taken_i,
   input  logic       mem_ready_i,
   output logic       imem_req_o,
   output logic       dmem_req_o,
   output logic       mem_write_o,
   output logic       ir_write_o,
   output logic       pc_write_o,
   output logic       pc_src_o,
   output logic       alu_src_o,
   output logic       mem_to_reg_o,
   output logic       reg_write_o,
   output logic [1:0] auipc_lui_o,
   output logic [2:0] state_o,
   output logic       illegal_o
);

   state_e       state_q, state_d;
   instr_class_e class_q, class_d;
   logic         illegal_q, illegal_d;
   instr_class_e dec_class;
   logic         dec_legal;

   instr_class_decode u_decode (
      .opcode_i (opcode_i),
      .class_o  (dec_class),
      .legal_o  (dec_legal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         class_q   <= CLS_R;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      class_d      = class_q;
      illegal_d    = illegal_q;
      imem_req_o   = 1'b0;
      dmem_req_o   = 1'b0;
      mem_write_o  = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      pc_src_o     = 1'b0;
      alu_src_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      reg_write_o  = 1'b0;
      auipc_lui_o  = ALU_A_RS1;

      case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            imem_req_o = 1'b1;
            if (mem_ready_i) begin
               ir_write_o = 1'b1;
               state_d    = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (dec_legal) begin
               class_d = dec_class;
               state_d = ST_EXEC;
            end else begin
               illegal_d = 1'b1;
               state_d   = ST_TRAP;
            end
         end
         ST_EXEC: begin
            alu_src_o   = alu_src_of(class_q);
            auipc_lui_o = alu_a_sel_of(class_q);
            // Branches resolve here, so the PC update is a Mealy output of br_taken_i.
            case (class_q)
               CLS_BRANCH: begin
                  pc_write_o = 1'b1;
                  pc_src_o   = br_taken_i;
                  state_d    = ST_FETCH;
               end
               CLS_LOAD, CLS_STORE: state_d = ST_MEM;
               default:             state_d = ST_WB;
            endcase
         end
         ST_MEM: begin
            dmem_req_o  = 1'b1;
            mem_write_o = (class_q == CLS_STORE);
            if (mem_ready_i) begin
               if (class_q == CLS_STORE) begin
                  pc_write_o = 1'b1;
                  state_d    = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end
         end
         ST_WB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = (class_q == CLS_LOAD);
            pc_write_o   = 1'b1;
            alu_src_o    = alu_src_of(class_q);
            auipc_lui_o  = alu_a_sel_of(class_q);
            state_d      = ST_FETCH;
         end
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_IDLE;
      endcase
   end

   assign state_o   = state_q;
   assign illegal_o = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected vectors of
// {state, strobes, AuipcLui, ILLEGAL} computed by hand for each instruction type.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode_i;
   logic       br_taken_i;
   logic       mem_ready_i;
   logic       imem_req_o, dmem_req_o, mem_write_o, ir_write_o, pc_write_o, pc_src_o;
   logic       alu_src_o, mem_to_reg_o, reg_write_o, illegal_o;
   logic [1:0] auipc_lui_o;
   logic [2:0] state_o;

   int tests_run = 0;
   int tests_failed = 0;

   multicycle_control dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .opcode_i     (opcode_i),
      .br_taken_i   (br_taken_i),
      .mem_ready_i  (mem_ready_i),
      .imem_req_o   (imem_req_o),
      .dmem_req_o   (dmem_req_o),
      .mem_write_o  (mem_write_o),
      .ir_write_o   (ir_write_o),
      .pc_write_o   (pc_write_o),
      .pc_src_o     (pc_src_o),
      .alu_src_o    (alu_src_o),
      .mem_to_reg_o (mem_to_reg_o),
      .reg_write_o  (reg_write_o),
      .auipc_lui_o  (auipc_lui_o),
      .state_o      (state_o),
      .illegal_o    (illegal_o)
   );

   always #5 clk = ~clk;

   // Strobe order: {imem, dmem, mem_write, ir_write, pc_write, pc_src, alu_src, mem_to_reg, reg_write}
   localparam logic [8:0] S_NONE   = 9'b000000000;
   localparam logic [8:0] S_FETCH  = 9'b100100000;
   localparam logic [8:0] S_FWAIT  = 9'b100000000;
   localparam logic [8:0] S_EXEC_I = 9'b000000100;

   function automatic logic [14:0] observe();
      return {state_o, imem_req_o, dmem_req_o, mem_write_o, ir_write_o, pc_write_o,
              pc_src_o, alu_src_o, mem_to_reg_o, reg_write_o, auipc_lui_o, illegal_o};
   endfunction

   task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got st=%0d sb=%b al=%0d il=%b, expected st=%0d sb=%b al=%0d il=%b",
                  tag, got[14:12], got[11:3], got[2:1], got[0],
                  exp[14:12], exp[11:3], exp[2:1], exp[0]);
      end
   endtask

   // Check the current cycle at the falling edge, then move just past the next rising edge.
   task automatic cyc(input string tag, input logic [2:0] st, input logic [8:0] sb,
                      input logic [1:0] al, input logic il);
      @(negedge clk);
      check(tag, observe(), {st, sb, al, il});
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      opcode_i    = 7'b0110011;
      br_taken_i  = 1'b0;
      mem_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset", observe(), {3'd0, S_NONE, 2'd2, 1'b0});
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ADD: 1,2,3,5
      cyc("add_fetch",  3'd1, S_FETCH,      2'd2, 1'b0);
      cyc("add_decode", 3'd2, S_NONE,       2'd2, 1'b0);
      cyc("add_exec",   3'd3, S_NONE,       2'd2, 1'b0);
      cyc("add_wb",     3'd5, 9'b000010001, 2'd2, 1'b0);

      // LW with two MEM wait cycles
      opcode_i = 7'b0000011;
      cyc("lw_fetch",  3'd1, S_FETCH,  2'd2, 1'b0);
      cyc("lw_decode", 3'd2, S_NONE,   2'd2, 1'b0);
      cyc("lw_exec",   3'd3, S_EXEC_I, 2'd2, 1'b0);
      mem_ready_i = 1'b0;
      cyc("lw_mem0", 3'd4, 9'b010000000, 2'd2, 1'b0);
      cyc("lw_mem1", 3'd4, 9'b010000000, 2'd2, 1'b0);
      mem_ready_i = 1'b1;
      cyc("lw_mem2", 3'd4, 9'b010000000, 2'd2, 1'b0);
      cyc("lw_wb",   3'd5, 9'b000010111, 2'd2, 1'b0);

      // SW
      opcode_i = 7'b0100011;
      cyc("sw_fetch",  3'd1, S_FETCH,      2'd2, 1'b0);
      cyc("sw_decode", 3'd2, S_NONE,       2'd2, 1'b0);
      cyc("sw_exec",   3'd3, S_EXEC_I,     2'd2, 1'b0);
      cyc("sw_mem",    3'd4, 9'b011010000, 2'd2, 1'b0);

      // BEQ taken, then not taken
      opcode_i   = 7'b1100011;
      br_taken_i = 1'b1;
      cyc("beq1_fetch",  3'd1, S_FETCH,      2'd2, 1'b0);
      cyc("beq1_decode", 3'd2, S_NONE,       2'd2, 1'b0);
      cyc("beq1_exec",   3'd3, 9'b000011000, 2'd2, 1'b0);
      br_taken_i = 1'b0;
      cyc("beq0_fetch",  3'd1, S_FETCH,      2'd2, 1'b0);
      cyc("beq0_decode", 3'd2, S_NONE,       2'd2, 1'b0);
      cyc("beq0_exec",   3'd3, 9'b000010000, 2'd2, 1'b0);

      // LUI then AUIPC, opcode scrambled once the class is registered
      opcode_i = 7'b0110111;
      cyc("lui_fetch",  3'd1, S_FETCH, 2'd2, 1'b0);
      cyc("lui_decode", 3'd2, S_NONE,  2'd2, 1'b0);
      opcode_i = 7'b0000000;
      cyc("lui_exec", 3'd3, S_EXEC_I,     2'd1, 1'b0);
      cyc("lui_wb",   3'd5, 9'b000010101, 2'd1, 1'b0);
      opcode_i = 7'b0010111;
      cyc("auipc_fetch",  3'd1, S_FETCH, 2'd2, 1'b0);
      cyc("auipc_decode", 3'd2, S_NONE,  2'd2, 1'b0);
      opcode_i = 7'b0000000;
      cyc("auipc_exec", 3'd3, S_EXEC_I,     2'd0, 1'b0);
      cyc("auipc_wb",   3'd5, 9'b000010101, 2'd0, 1'b0);

      // Illegal opcode: trap is sticky, MEM_READY toggling is ignored
      opcode_i = 7'b1111111;
      cyc("ill_fetch",  3'd1, S_FETCH, 2'd2, 1'b0);
      cyc("ill_decode", 3'd2, S_NONE,  2'd2, 1'b0);
      opcode_i = 7'b0110011;
      for (int i = 0; i < 20; i++) begin
         mem_ready_i = i[0];
         cyc($sformatf("trap_%0d", i), 3'd6, S_NONE, 2'd2, 1'b1);
      end

      // Asynchronous reset out of TRAP clears ILLEGAL without a clock edge
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("trap_rst", observe(), {3'd0, S_NONE, 2'd2, 1'b0});
      @(posedge clk);
      #1;
      mem_ready_i = 1'b0;
      rst_n       = 1'b1;
      cyc("idle_after_rst", 3'd0, S_NONE,  2'd2, 1'b0);
      cyc("fwait0",         3'd1, S_FWAIT, 2'd2, 1'b0);
      cyc("fwait1",         3'd1, S_FWAIT, 2'd2, 1'b0);

      // Reset mid-FETCH wait drops IMEM_REQ immediately, no IR_WRITE
      @(negedge clk);
      check("fwait2", observe(), {3'd1, S_FWAIT, 2'd2, 1'b0});
      #1;
      mem_ready_i = 1'b1;
      rst_n       = 1'b0;
      #1;
      check("fetch_rst", observe(), {3'd0, S_NONE, 2'd2, 1'b0});
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc("idle_again", 3'd0, S_NONE,  2'd2, 1'b0);
      cyc("fetch_again", 3'd1, S_FETCH, 2'd2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all ports are listed below, clock and reset first.
REQ-002 CLK  in  1  rising-edge clock.
REQ-003 RST_N  in  1  asynchronous, active-low reset.
REQ-004 OPCODE  in  7  instr[6:0] from IR, valid from DECODE onward.
REQ-005 BR_TAKEN  in  1  branch compare result, sampled in EXEC.
REQ-006 MEM_READY  in  1  memory access complete, sampled in FETCH/MEM only.
REQ-007 IMEM_REQ  out  1  instruction fetch request.
REQ-008 DMEM_REQ  out  1  data access request; MEM_WRITE  out  1  data write qualifier.
REQ-009 IR_WRITE  out  1; PC_WRITE  out  1; PC_SRC  out  1 (0 = PC+4, 1 = branch target).
REQ-010 ALU_SRC, MEM_TO_REG, REG_WRITE  out  1 each; AuipcLui  out  2 (0 = PC, 1 = zero, 2 = rs1 as ALU A).
REQ-011 STATE  out  3  current state code; ILLEGAL  out  1  sticky illegal-opcode flag.

Function
REQ-012 States and codes: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, TRAP 6; all strobes default 0 and AuipcLui defaults to 2.
REQ-013 IDLE: all strobes 0; next edge -> FETCH.
REQ-014 FETCH: IMEM_REQ = 1 held until MEM_READY = 1; in that cycle IR_WRITE = 1 and next state is DECODE; MEM_READY = 0 -> stay, outputs unchanged.
REQ-015 DECODE: classify OPCODE and register the class: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, AUIPC 0010111, LUI 0110111; legal -> EXEC, any other value -> TRAP.
REQ-016 All states after DECODE use only the registered class, never live OPCODE.
REQ-017 EXEC: ALU_SRC = 1 for I-ALU/LOAD/STORE/AUIPC/LUI, 0 for R/BRANCH; AuipcLui = 0 for AUIPC, 1 for LUI, 2 otherwise.
REQ-018 EXEC, BRANCH: PC_WRITE = 1 and PC_SRC = BR_TAKEN (same-cycle, Mealy) -> FETCH; LOAD/STORE -> MEM; others -> WB.
REQ-019 MEM: DMEM_REQ = 1 and MEM_WRITE = (class == STORE), held until MEM_READY = 1.
REQ-020 MEM on MEM_READY: LOAD -> WB; STORE -> PC_WRITE = 1, PC_SRC = 0 in that cycle -> FETCH.
REQ-021 WB: REG_WRITE = 1, MEM_TO_REG = (class == LOAD), PC_WRITE = 1, PC_SRC = 0; AuipcLui/ALU_SRC held at EXEC values -> FETCH.
REQ-022 TRAP: all strobes 0, ILLEGAL = 1, no exit except reset.
REQ-023 Latency in cycles, MEM_READY always high: R/I-ALU/AUIPC/LUI 4, LOAD 5, STORE 4, BRANCH 3; each wait cycle adds 1.
REQ-024 MEM_READY asserted in IDLE, DECODE, EXEC, WB or TRAP SHALL be ignored.
REQ-025 At most one of IMEM_REQ and DMEM_REQ is 1 in any cycle; PC_WRITE is 1 at most once per instruction.

Reset
REQ-026 RST_N low SHALL force state IDLE, class register cleared to R, and ILLEGAL = 0 asynchronously.
REQ-027 While RST_N is low, every output is 0 except AuipcLui = 2.
REQ-028 Reset asserted mid-access (FETCH/MEM waiting) SHALL drop IMEM_REQ/DMEM_REQ immediately with no completion strobe.
REQ-029 After RST_N rises, the first edge moves IDLE -> FETCH.

Structure
REQ-030 Opcode constants, state enum (3-bit) and class enum SHALL live in the shared instruction_type package next to the existing format constants, with LOAD added.
REQ-031 Opcode-to-class mapping SHALL be one combinational sub-module, instr_class_decode (OPCODE in, class and legal out); the FSM and output logic stay in multicycle_control.

Verification
REQ-032 ADD 0110011, MEM_READY = 1 -> STATE 1,2,3,5,1; REG_WRITE only in WB; ALU_SRC = 0; PC_WRITE once with PC_SRC = 0.
REQ-033 LW 0000011, MEM_READY low 2 cycles in MEM -> DMEM_REQ = 1 for 3 cycles with MEM_WRITE = 0; WB has MEM_TO_REG = 1; total 7 cycles.
REQ-034 SW 0100011 -> MEM: DMEM_REQ = MEM_WRITE = 1; REG_WRITE never 1; PC_WRITE in the MEM completion cycle -> FETCH.
REQ-035 BEQ 1100011, BR_TAKEN = 1 then a second BEQ with 0 -> EXEC: PC_WRITE = 1 with PC_SRC 1 then 0; 3 cycles each; no REG_WRITE.
REQ-036 LUI 0110111 then AUIPC 0010111 -> AuipcLui 1 then 0 in EXEC and WB; ALU_SRC = 1; OPCODE changed to 0000000 after DECODE does not alter outputs.
REQ-037 Opcode 1111111 -> TRAP (6), ILLEGAL = 1, held 20 cycles; RST_N pulsed low mid-FETCH wait -> IDLE, IMEM_REQ = 0 immediately, ILLEGAL = 0.
